// File: rtl/spi_arbiter.sv
// Round-robin sequencer that shares one spi master between N requesters.
// Latches the winner's frame/chip-select, runs the send_enable/ready handshake and returns rx data.
module spi_arbiter #(
    parameter int N       = 2,
    parameter int SIZE    = 40,
    parameter int CS_SIZE = 2,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255,
    localparam int CSW    = (CS_SIZE > 2) ? $clog2(CS_SIZE) : 1
) (
    input  logic                internal_clk,
    input  logic                reset_n_in,
    input  logic [N-1:0]        req_in,
    input  logic [N*SIZE-1:0]   req_data_in,
    input  logic [N*CSW-1:0]    req_cs_in,
    output logic [N-1:0]        grant_out,
    output logic [N-1:0]        done_out,
    output logic [N-1:0]        err_out,
    output logic [SIZE-1:0]     rx_data_out,
    output logic                busy_out,
    output logic [SIZE-1:0]     spi_data_out,
    output logic [CSW-1:0]      spi_cs_select_out,
    output logic                spi_send_enable_out,
    input  logic                spi_ready_in,
    input  logic [SIZE-1:0]     spi_data_in,
    output logic [2:0]          state_dbg_out
);

    localparam int IDXW = $clog2(N);
    localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);
    localparam logic [7:0] GAP_LIM = 8'(GAP);

    // Handshake: send_enable is held high from START entry until the spi
    // raises ready again (XFER exit) or the wait counter expires.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_XFER  = 3'd3,
        S_DONE  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    done_q, done_d;
    logic [N-1:0]    err_q, err_d;
    logic [SIZE-1:0] rx_q, rx_d;
    logic            busy_q, busy_d;
    logic [SIZE-1:0] data_q, data_d;
    logic [CSW-1:0]  cs_q, cs_d;
    logic            send_q, send_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            found;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] win_next;

    // Rotating priority scan starting at the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_in[idx]) begin
                found = 1'b1;
                win   = IDXW'(idx);
            end
        end
        win_next = (int'(win) == N - 1) ? '0 : win + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        rx_d    = rx_q;
        data_d  = data_q;
        cs_d    = cs_q;
        send_d  = send_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (|req_in) state_d = S_ARB;
            end
            S_ARB: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    data_d       = req_data_in[int'(win)*SIZE +: SIZE];
                    cs_d         = req_cs_in[int'(win)*CSW +: CSW];
                    owner_d      = win;
                    ptr_d        = win_next;
                    send_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START, S_XFER: begin
                if (state_q == S_START && !spi_ready_in) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (state_q == S_XFER && spi_ready_in) begin
                    rx_d            = spi_data_in;
                    done_d[owner_q] = 1'b1;
                    send_d          = 1'b0;
                    grant_d         = '0;
                    state_d         = S_DONE;
                end else if (cnt_q + 8'd1 == TO_LIM) begin
                    // Stalled spi: abort, keep the previous rx frame.
                    err_d[owner_q] = 1'b1;
                    send_d         = 1'b0;
                    grant_d        = '0;
                    cnt_d          = '0;
                    state_d        = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q + 8'd1 >= GAP_LIM) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                send_d  = 1'b0;
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge internal_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            cs_q    <= '0;
            send_q  <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            send_q  <= send_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_out           = grant_q;
    assign done_out            = done_q;
    assign err_out             = err_q;
    assign rx_data_out         = rx_q;
    assign busy_out            = busy_q;
    assign spi_data_out        = data_q;
    assign spi_cs_select_out   = cs_q;
    assign spi_send_enable_out = send_q;
    assign state_dbg_out       = state_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter (N=3): randomized rounds of requests against a behavioural
// round-robin model, with an spi slave model and a completion scoreboard.
module tb_spi_arbiter;

    localparam int N       = 3;
    localparam int SIZE    = 40;
    localparam int CS_SIZE = 2;
    localparam int CSW     = 1;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic [1:0]      owner;
        logic [SIZE-1:0] data;
        logic [CSW-1:0]  cs;
        logic            is_err;
        logic            stall;
        logic [SIZE-1:0] rx;
    } exp_t;

    // kind: 0 normal, 1 ready never drops, 2 ready drops but never returns
    typedef struct packed {
        logic [1:0]      kind;
        logic [7:0]      d;
        logic [7:0]      r;
        logic [SIZE-1:0] rx;
    } beh_t;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req;
    logic [N*SIZE-1:0]   req_data;
    logic [N*CSW-1:0]    req_cs;
    logic [N-1:0]        grant, done, err;
    logic [SIZE-1:0]     rx_data, spi_data;
    logic                busy, spi_en;
    logic [CSW-1:0]      spi_cs;
    logic                spi_ready = 1'b1;
    logic [SIZE-1:0]     spi_rx = '0;
    logic [2:0]          state_dbg;

    exp_t exp_q[$];
    beh_t beh_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_ptr = 0;
    logic [SIZE-1:0] model_rx = '0;
    int   sp_phase = 0;

    spi_arbiter #(.N(N), .SIZE(SIZE), .CS_SIZE(CS_SIZE), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .internal_clk(clk), .reset_n_in(rst_n), .req_in(req), .req_data_in(req_data),
        .req_cs_in(req_cs), .grant_out(grant), .done_out(done), .err_out(err),
        .rx_data_out(rx_data), .busy_out(busy), .spi_data_out(spi_data),
        .spi_cs_select_out(spi_cs), .spi_send_enable_out(spi_en), .spi_ready_in(spi_ready),
        .spi_data_in(spi_rx), .state_dbg_out(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // spi slave model: ready idles high, drops d cycles after enable, returns r later.
    beh_t cur;
    int   sp_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sp_phase  = 0;
            spi_ready = 1'b1;
        end else begin
            case (sp_phase)
                0: if (spi_en) begin
                    if (beh_q.size() > 0) cur = beh_q.pop_front();
                    else cur = '{kind: 2'd1, d: 8'd1, r: 8'd1, rx: '0};
                    sp_cnt   = 0;
                    sp_phase = (cur.kind == 2'd1) ? 3 : 1;
                end
                1: begin
                    sp_cnt++;
                    if (sp_cnt >= int'(cur.d)) begin
                        spi_ready = 1'b0;
                        sp_cnt    = 0;
                        sp_phase  = (cur.kind == 2'd2) ? 3 : 2;
                    end
                end
                2: begin
                    sp_cnt++;
                    if (sp_cnt >= int'(cur.r)) begin
                        spi_rx    = cur.rx;
                        spi_ready = 1'b1;
                        sp_phase  = 3;
                    end
                end
                default: if (!spi_en) begin
                    spi_ready = 1'b1;
                    sp_phase  = 0;
                end
            endcase
        end
    end

    // Monitor: checks each granted transaction at enable rise and at its completion pulse.
    logic prev_en = 1'b0;
    bit   seen_en = 1'b0;
    int   en_cnt = 0;
    int   low_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_en = 1'b0;
            seen_en = 1'b0;
            en_cnt  = 0;
            low_cnt = 0;
        end else begin
            if (spi_en && !prev_en) begin
                if (seen_en) begin
                    n_checks++;
                    if (low_cnt < GAP + 2) begin
                        n_fail++;
                        $display("FAIL enable_gap: got %0d idle cycles expected >= %0d", low_cnt, GAP + 2);
                    end
                end
                seen_en = 1'b1;
                en_cnt  = 1;
                low_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_enable: got grant %b expected no transaction", grant);
                end else begin
                    e = exp_q[0];
                    chk("grant", 64'(grant), 64'(1) << e.owner);
                    chk("spi_data", 64'(spi_data), 64'(e.data));
                    chk("spi_cs", 64'(spi_cs), 64'(e.cs));
                end
            end else if (spi_en) begin
                en_cnt++;
            end else begin
                low_cnt++;
            end
            prev_en = spi_en;

            if ((done | err) != '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got done %b err %b expected none", done, err);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_out", 64'(done), e.is_err ? 64'd0 : (64'(1) << e.owner));
                    chk("err_out", 64'(err), e.is_err ? (64'(1) << e.owner) : 64'd0);
                    chk("rx_data", 64'(rx_data), 64'(e.rx));
                    if (e.is_err) chk("err_enable_low", 64'(spi_en), 64'd0);
                    if (e.stall) chk("timeout_cycles", 64'(en_cnt), 64'(TIMEOUT));
                end
            end
        end
    end

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) begin
            req_data[i*SIZE +: SIZE] = SIZE'({$urandom, $urandom});
            req_cs[i*CSW +: CSW]     = CSW'($urandom_range(0, CS_SIZE - 1));
        end
    endtask

    // Reference: requesters in mask m are served in rotation from the pointer.
    task automatic plan(input logic [N-1:0] m, input int mode, input int d, input int r);
        int last;
        last = -1;
        for (int k = 0; k < N; k++) begin
            int   i;
            int   kind;
            int   x;
            exp_t e;
            beh_t b;
            i = (model_ptr + k) % N;
            if (m[i]) begin
                kind = mode;
                b.d  = 8'(d);
                b.r  = 8'(r);
                if (mode < 0) begin
                    x    = $urandom_range(0, 9);
                    kind = (x == 0) ? 1 : (x == 1) ? 2 : 0;
                    b.d  = 8'($urandom_range(1, 6));
                    b.r  = 8'($urandom_range(1, 50));
                end
                b.kind   = 2'(kind);
                b.rx     = SIZE'({$urandom, $urandom});
                e.owner  = 2'(i);
                e.data   = req_data[i*SIZE +: SIZE];
                e.cs     = req_cs[i*CSW +: CSW];
                e.is_err = (kind != 0);
                e.stall  = (kind == 1);
                if (kind == 0) model_rx = b.rx;
                e.rx = model_rx;
                exp_q.push_back(e);
                beh_q.push_back(b);
                last = i;
            end
        end
        if (last >= 0) model_ptr = (last + 1) % N;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done_err"}, 64'({done, err}), 64'd0);
        chk({tag, "_busy_en"}, 64'({busy, spi_en}), 64'd0);
        chk({tag, "_spi_data"}, 64'(spi_data), 64'd0);
        chk({tag, "_spi_cs"}, 64'(spi_cs), 64'd0);
        chk({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        exp_q.delete();
        beh_q.delete();
        model_ptr = 0;
        model_rx  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on a negedge with the DUT idle; returns once every planned transaction completed.
    task automatic go(input logic [N-1:0] m, input logic [N-1:0] drop_early, input bit lat_chk);
        int cyc;
        req = m;
        if (lat_chk) begin
            @(negedge clk);
            chk("latency_arb_en", 64'({busy, spi_en}), 64'b10);
            @(negedge clk);
            chk("latency_start_en", 64'(spi_en), 64'd1);
        end
        cyc = 0;
        while (!(exp_q.size() == 0 && req == '0 && !busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (done[i] || err[i]) req[i] = 1'b0;
                if (drop_early[i] && grant[i] && sp_phase == 2) req[i] = 1'b0;
            end
        end
        if (cyc >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL round_timeout: got %0d pending transactions expected 0", exp_q.size());
            apply_reset();
        end
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        req_cs   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, fixed frame, spi drops ready after 3 and returns 44 cycles in.
        randomize_inputs();
        req_data[0 +: SIZE] = 40'hA5_1234_5678;
        req_cs[0 +: CSW]    = 1'b1;
        plan(3'b001, 0, 3, 41);
        go(3'b001, 3'b000, 1'b1);

        // Two requesters held: alternating grants.
        randomize_inputs();
        plan(3'b011, 0, 2, 10);
        go(3'b011, 3'b000, 1'b0);
        randomize_inputs();
        plan(3'b011, 0, 4, 7);
        go(3'b011, 3'b000, 1'b0);

        // Stalled spi (ready never drops) and stuck-low spi both time out.
        randomize_inputs();
        plan(3'b001, 1, 1, 1);
        go(3'b001, 3'b000, 1'b0);
        randomize_inputs();
        plan(3'b010, 2, 3, 1);
        go(3'b010, 3'b000, 1'b0);

        // Requester 1 withdraws during XFER; its transfer still completes.
        randomize_inputs();
        plan(3'b010, 0, 2, 20);
        go(3'b010, 3'b010, 1'b0);

        // Reset during XFER of requester 0, then both 0 and 1 request: 0 must win.
        randomize_inputs();
        plan(3'b001, 0, 2, 60);
        req = 3'b001;
        cyc = 0;
        while (sp_phase != 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_xfer", 64'(sp_phase), 64'd2);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        apply_reset();
        @(negedge clk);
        randomize_inputs();
        plan(3'b011, 0, 1, 5);
        go(3'b011, 3'b000, 1'b0);

        // Only requester 2, then 0 and 1: pointer wraps so 0 goes next.
        apply_reset();
        @(negedge clk);
        randomize_inputs();
        plan(3'b100, 0, 2, 6);
        go(3'b100, 3'b000, 1'b0);
        randomize_inputs();
        plan(3'b011, 0, 2, 6);
        go(3'b011, 3'b000, 1'b0);

        // All three requesting: full rotation.
        randomize_inputs();
        plan(3'b111, 0, 1, 3);
        go(3'b111, 3'b000, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [N-1:0] m;
            logic [N-1:0] drop;
            m    = N'($urandom_range(1, (1 << N) - 1));
            drop = N'($urandom_range(0, (1 << N) - 1));
            randomize_inputs();
            plan(m, -1, 0, 0);
            go(m, drop, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'({busy, spi_en, grant}), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
